// File: rtl/mch_test_unit_pkg.sv
// mch_test_unit_pkg: FSM state type, pattern seed base, LFSR taps per width and pattern seed/step helpers.
// Build option MCH_TEST_UNIT_LFSR_EN: patterns are Galois LFSR sequences instead of per-channel counters.
package mch_test_unit_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [63:0] SEED_BASE = 64'h9E37_79B9_7F4A_7C15;

    function automatic logic [63:0] dw_mask(input int dw);
        return dw >= 64 ? '1 : (64'd1 << dw) - 64'd1;
    endfunction

    // Right-shifting Galois taps; unknown widths fall back to a top-bit/bottom-bit polynomial.
    function automatic logic [63:0] lfsr_taps(input int dw);
        case (dw)
            8:       return 64'hB8;
            16:      return 64'hB400;
            32:      return 64'h8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return (64'd1 << (dw - 1)) | 64'd1;
        endcase
    endfunction

    // First beat of channel c. The LFSR seed keeps bit 4 of SEED_BASE set, so it is never zero.
    function automatic logic [63:0] pat_seed(input int c, input int dw);
`ifdef MCH_TEST_UNIT_LFSR_EN
        return (SEED_BASE ^ 64'(c)) & dw_mask(dw);
`else
        return (64'(c) << (dw - 8)) & dw_mask(dw);
`endif
    endfunction

    // Value following x (x is zero-extended from dw bits).
    function automatic logic [63:0] pat_next(input logic [63:0] x, input int dw);
`ifdef MCH_TEST_UNIT_LFSR_EN
        return ((x >> 1) ^ (x[0] ? lfsr_taps(dw) : 64'd0)) & dw_mask(dw);
`else
        return (x + 64'd1) & dw_mask(dw);
`endif
    endfunction

endpackage

// File: rtl/mch_test_unit_pattern.sv
// mch_test_unit_pattern: pattern register that loads a seed and advances one step per enabled cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i/seed_i load a seed (priority over step);
//        step_i advances the pattern; val_o current pattern value (0 after reset).
module mch_test_unit_pattern
    import mch_test_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] seed_i,
    input  logic          step_i,
    output logic [DW-1:0] val_o
);

    logic [DW-1:0] val_q, val_d;

    assign val_d = load_i ? seed_i : step_i ? DW'(pat_next(64'(val_q), DW)) : val_q;
    assign val_o = val_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) val_q <= '0;
        else         val_q <= val_d;
    end

endmodule

// File: rtl/mch_test_unit.sv
// mch_test_unit: multi-channel loopback self-test; drives a pattern per TX stream, checks the RX stream.
// Build option MCH_TEST_UNIT_LFSR_EN selects the LFSR pattern (ports and timing unchanged).
// Ports: clk_i, rst_ni (async active-low); start_i pulse + run_len_i beats per channel;
//        tx_data_o/tx_valid_o/tx_ready_i and rx_data_i/rx_valid_i/rx_ready_o per-channel streams;
//        busy_o (RUN/DRAIN), done_o (1-cycle pulse), pass_o/timeout_o (held until next start),
//        err_cnt_o saturating per-channel mismatch counts.
module mch_test_unit
    import mch_test_unit_pkg::*;
#(
    parameter int CH  = 4,
    parameter int DW  = 32,
    parameter int LW  = 16,
    parameter int EW  = 8,
    parameter int TMO = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LW-1:0]    run_len_i,
    output logic [CH*DW-1:0] tx_data_o,
    output logic [CH-1:0]    tx_valid_o,
    input  logic [CH-1:0]    tx_ready_i,
    input  logic [CH*DW-1:0] rx_data_i,
    input  logic [CH-1:0]    rx_valid_i,
    output logic [CH-1:0]    rx_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [CH*EW-1:0] err_cnt_o
);

    localparam int TW = $clog2(TMO) + 1;

    state_e        state_q;
    logic [LW-1:0] run_len_q;
    logic [TW-1:0] tmo_q;
    logic          busy_q, done_q, pass_q, timeout_q;
    logic [CH-1:0] tx_left, rx_left, tx_fire, rx_fire, err_nz;
    logic          load, tmo_hit;

    assign load    = start_i && (state_q == IDLE || state_q == DONE);
    // A beat arriving in the last idle cycle still counts as progress.
    assign tmo_hit = tmo_q == TW'(TMO - 1) && !(|rx_fire);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [LW-1:0] tx_cnt_q, rx_cnt_q;
        logic [EW-1:0] err_q;
        logic [DW-1:0] exp_v;
        logic          mism;
        assign tx_left[c]    = tx_cnt_q < run_len_q;
        assign rx_left[c]    = rx_cnt_q < run_len_q;
        assign tx_valid_o[c] = state_q == RUN && tx_left[c];
        assign rx_ready_o[c] = (state_q == RUN || state_q == DRAIN) && rx_left[c];
        assign tx_fire[c]    = tx_valid_o[c] & tx_ready_i[c];
        assign rx_fire[c]    = rx_valid_i[c] & rx_ready_o[c];
        assign mism          = rx_fire[c] && rx_data_i[c*DW +: DW] != exp_v;
        assign err_nz[c]     = |err_q;
        assign err_cnt_o[c*EW +: EW] = err_q;
        mch_test_unit_pattern #(.DW(DW)) u_tx (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (load),
            .seed_i (DW'(pat_seed(c, DW))),
            .step_i (tx_fire[c]),
            .val_o  (tx_data_o[c*DW +: DW])
        );
        mch_test_unit_pattern #(.DW(DW)) u_rx (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (load),
            .seed_i (DW'(pat_seed(c, DW))),
            .step_i (rx_fire[c]),
            .val_o  (exp_v)
        );
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                err_q    <= '0;
            end else if (load) begin
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                err_q    <= '0;
            end else begin
                if (tx_fire[c]) tx_cnt_q <= tx_cnt_q + 1'b1;
                if (rx_fire[c]) rx_cnt_q <= rx_cnt_q + 1'b1;
                if (mism && err_q != '1) err_q <= err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= |rx_fire ? '0 : state_q == DRAIN ? tmo_q + 1'b1 : tmo_q;
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_q   <= RUN;
                    run_len_q <= run_len_i;
                    tmo_q     <= '0;
                    busy_q    <= 1'b1;
                    pass_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
                RUN: if (tx_left == '0) state_q <= DRAIN;
                DRAIN: if (rx_left == '0 || tmo_hit) begin
                    state_q   <= DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    timeout_q <= rx_left != '0;
                    pass_q    <= rx_left == '0 && err_nz == '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mch_test_unit.sv
// tb_mch_test_unit: loopback bench with FIFO return path, scoreboarded run results and TX pattern checks.
module tb_mch_test_unit;

    localparam int CH = 4, DW = 32, LW = 16, EW = 8, TMO = 1024;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [LW-1:0]    run_len = '0;
    logic [CH*DW-1:0] tx_data, rx_data;
    logic [CH-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
    logic             busy, done, pass, timeout;
    logic [CH*EW-1:0] err_cnt;

    always #5 clk = ~clk;

    mch_test_unit #(.CH(CH), .DW(DW), .LW(LW), .EW(EW), .TMO(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .run_len_i(run_len),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout), .err_cnt_o(err_cnt)
    );

    typedef struct {
        logic             p;
        logic             t;
        logic [CH*EW-1:0] e;
        int               lat;
        logic             from_rx;
        int               id;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, last_rx_cyc = 0, tx_total = 0;
    logic rnd = 1'b0, flush = 1'b1, corrupt_one = 1'b0;
    logic [CH-1:0] drop = '0, corrupt_all = '0, rnd_tx = '1, rnd_rx = '1;
    logic [DW-1:0] fm [CH][256];
    int wp [CH], rp [CH];
    logic [DW-1:0] exp_tx [CH];
    logic [CH-1:0] cap_v = '0, cap_r = '0, pv = '0, pr = '0;
    logic [CH*DW-1:0] cap_d = '0, pd = '0;
    logic cap_st = 1'b0;

    function automatic logic [DW-1:0] pseed(input int c);
`ifdef MCH_TEST_UNIT_LFSR_EN
        return 32'h7F4A_7C15 ^ DW'(c);
`else
        return DW'(c) << (DW - 8);
`endif
    endfunction

    function automatic logic [DW-1:0] pnext(input logic [DW-1:0] x);
`ifdef MCH_TEST_UNIT_LFSR_EN
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
`else
        return x + 32'd1;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    assign tx_ready = rnd ? rnd_tx : '1;

    always_comb begin
        rx_valid = '0;
        rx_data  = '0;
        for (int c = 0; c < CH; c++) begin
            rx_valid[c] = wp[c] != rp[c] && (rnd ? rnd_rx[c] : 1'b1) && !drop[c];
            rx_data[c*DW +: DW] = fm[c][rp[c] & 255];
        end
    end

    always @(negedge clk) if (rnd) begin
        rnd_tx = CH'($urandom);
        rnd_rx = CH'($urandom);
    end

    // Loopback FIFOs plus capture of what the DUT saw at this edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        cap_v  <= rst_n ? tx_valid : '0;
        cap_r  <= tx_ready;
        cap_d  <= tx_data;
        cap_st <= rst_n && start && !busy;
        if (rst_n && (rx_valid & rx_ready) != '0) last_rx_cyc <= cyc;
        for (int c = 0; c < CH; c++) begin
            if (flush) begin
                wp[c] <= 0;
                rp[c] <= 0;
            end else begin
                if (rst_n && tx_valid[c] && tx_ready[c]) begin
                    fm[c][wp[c] & 255] <= tx_data[c*DW +: DW] ^
                        DW'((corrupt_all[c] || (corrupt_one && c == 2 && wp[c] == 3)) ? 1 : 0);
                    wp[c] <= wp[c] + 1;
                end
                if (rst_n && rx_valid[c] && rx_ready[c]) rp[c] <= rp[c] + 1;
            end
        end
    end

    // Monitor: TX pattern/stability checks and scoreboard pop on done.
    always @(negedge clk) begin
        if (cap_st) for (int c = 0; c < CH; c++) exp_tx[c] = pseed(c);
        for (int c = 0; c < CH; c++) begin
            if (pv[c] && !pr[c] && cap_v[c])
                chk($sformatf("tx%0d_stable", c), 64'(cap_d[c*DW +: DW]), 64'(pd[c*DW +: DW]));
            if (cap_v[c] && cap_r[c]) begin
                chk($sformatf("tx%0d_data", c), 64'(cap_d[c*DW +: DW]), 64'(exp_tx[c]));
                exp_tx[c] = pnext(exp_tx[c]);
                tx_total++;
            end
        end
        pv = cap_v;
        pr = cap_r;
        pd = cap_d;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending run");
            end else begin
                cur = sb.pop_front();
                chk($sformatf("run%0d_pass", cur.id), 64'(pass), 64'(cur.p));
                chk($sformatf("run%0d_timeout", cur.id), 64'(timeout), 64'(cur.t));
                chk($sformatf("run%0d_err_cnt", cur.id), 64'(err_cnt), 64'(cur.e));
                if (cur.lat >= 0)
                    chk($sformatf("run%0d_latency", cur.id),
                        64'(cyc - 1 - (cur.from_rx ? last_rx_cyc : start_cyc)), 64'(cur.lat));
            end
        end
    end

    task automatic kick(input int len, input logic p, input logic t, input logic [CH*EW-1:0] e,
                        input int lat, input logic frx, input int id);
        exp_t x;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        x.p = p; x.t = t; x.e = e; x.lat = lat; x.from_rx = frx; x.id = id;
        sb.push_back(x);
        run_len   = LW'(len);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("run%0d_busy", id), 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run%0d_done_wait: got no done in %0d cycles, expected done", id, n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input int len, input logic p, input logic t, input logic [CH*EW-1:0] e,
                       input int lat, input logic frx, input int id);
        kick(len, p, t, e, lat, frx, id);
        wait_done(id);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data[63:0]), 64'd0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        base = tx_total;
        run(8, 1'b1, 1'b0, '0, 10, 1'b0, 1);
        chk("run1_tx_beats", 64'(tx_total - base), 64'd32);
        corrupt_one = 1'b1;
        run(8, 1'b0, 1'b0, 32'h0001_0000, 10, 1'b0, 2);
        corrupt_one = 1'b0;
        drop[1] = 1'b1;
        run(8, 1'b0, 1'b1, '0, TMO, 1'b1, 3);
        drop = '0;
        rnd = 1'b1;
        run(100, 1'b1, 1'b0, '0, -1, 1'b0, 4);
        rnd = 1'b0;
        base = tx_total;
        run(0, 1'b1, 1'b0, '0, 2, 1'b0, 5);
        chk("run5_tx_beats", 64'(tx_total - base), 64'd0);
        kick(100, 1'b1, 1'b0, '0, -1, 1'b0, 6);
        repeat (20) @(negedge clk);
        chk("run6_busy_mid", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 1'b1, 1'b0, '0, 6, 1'b0, 7);
        corrupt_all[0] = 1'b1;
        run(300, 1'b0, 1'b0, 32'h0000_00FF, -1, 1'b0, 8);
        corrupt_all = '0;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1000000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
